packet_assembler: RTL and testbench
===================================

Name: packet_assembler

Overview:
- Parametrised successor to the single-stream packet handler.
- Accepts a 32-bit beat stream with a two-word header and a variable payload, and packs the payload into a wide output word.
- Checks per-stream sequence numbers and payload length, and presents the result to a downstream consumer over valid/ready.
- Sits between the serial link receiver and the packet processing fabric.

Parameters:
- MAX_WORDS, 9: maximum payload beats stored per packet; output width is MAX_WORDS*32.
- NUM_STREAMS, 32: number of tracked streams; valid streamId range is 1..NUM_STREAMS.
- SEQ_W, 32: width of the sequence counter per stream (1..32); header seqNumber is truncated to SEQ_W.
- CNT_W, $clog2(MAX_WORDS+1): width of the payload word count.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_data  in  32  input beat.
- i_valid  in  1  input beat valid.
- i_last  in  1  marks the final beat of a packet; qualified by i_valid.
- o_ready  out  1  block can accept an input beat.
- o_data  out  MAX_WORDS*32  packed payload.
- o_valid  out  1  output packet valid.
- i_ready  in  1  downstream accepts the output packet.
- o_stream_id  out  16  streamId of the output packet.
- o_seq  out  SEQ_W  seqNumber of the output packet.
- o_word_count  out  CNT_W  number of payload beats stored.
- o_len_err  out  1  length error flag for the output packet; valid with o_valid.
- o_packetLost  out  1  one-cycle pulse on a sequence gap.
- o_drop  out  1  one-cycle pulse when a packet is discarded.

Behaviour:
- Reset: all outputs 0 except o_ready=1. FSM goes to IDLE and every tracker entry is cleared to 0. Reset is asynchronous and active-low and may assert mid-packet; the partial packet is lost with no pulse.
- Beat accepted when i_valid && o_ready.
- Header word 0: msgLength={d[23:16],d[31:24]}, streamId={d[7:0],d[15:8]}.
- Header word 1: seqNumber={d[7:0],d[15:8],d[23:16],d[31:24]}. All header fields are little endian per field.
- States:
  - IDLE: o_ready=1. An accepted beat latches word 0.
    - i_last also set -> runt packet: pulse o_drop, stay in IDLE.
    - streamId outside 1..NUM_STREAMS -> DISCARD.
    - otherwise -> HDR1.
  - HDR1: o_ready=1. An accepted beat latches seqNumber and performs the sequence check.
    - i_last also set -> OUT with word_count=0.
    - otherwise -> PAYLOAD.
  - PAYLOAD: o_ready=1. Accepted beat k (0-based) is written to o_data[32k+:32] if k<MAX_WORDS; beyond that the beat is dropped and the len_err flag is set. The word count saturates at MAX_WORDS.
    - Accepted beat with i_last -> OUT.
  - OUT: o_ready=0, o_valid=1. All outputs are held stable until i_ready.
    - o_valid && i_ready -> IDLE; o_valid falls and o_ready rises on the next cycle.
  - DISCARD: o_ready=1. Consumes beats until an accepted i_last, then pulses o_drop and goes to IDLE. The tracker is untouched.
- Payload buffer: cleared to 0 on entry to HDR1, so unused output words read 0.
- Sequence check (on HDR1 accept):
  - expected = tracker[streamId-1]+1, modulo 2^SEQ_W, so it wraps to 0.
  - If seqNumber != expected, o_packetLost pulses on the cycle after the HDR1 accept, exactly one cycle high.
  - tracker[streamId-1] <= seqNumber regardless of the result (resync).
- Length check: len_err is set if ceil(msgLength/4) != beats received, or if overflow occurred. It is computed when the last beat is accepted and presented with o_valid.
- Simultaneous events: an i_valid beat while in OUT is not accepted. o_packetLost and o_drop are independent and may both be high in one cycle.
- Latency: o_valid rises 1 cycle after the last beat is accepted.

Decomposition:
- Package packet_pkg:
  - one-hot state encodings: IDLE, HDR1, PAYLOAD, OUT, DISCARD;
  - header byte-lane constants;
  - helper function for byte-swapping header fields.
- Sub-module seq_tracker:
  - holds the NUM_STREAMS x SEQ_W tracker array with asynchronous reset;
  - inputs: index, seq, check strobe;
  - output: registered mismatch pulse.
- packet_assembler owns the FSM, the payload buffer and the length check.

Test Plan:
- Stream 3, seq 1, msgLength 12, 3 payload beats A,B,C, i_ready=1 -> o_valid one cycle after C is accepted; o_data[95:0]={C,B,A} with upper words 0; o_word_count=3; o_len_err=0; o_packetLost=0.
- Stream 3, seq 1 then seq 3 -> o_packetLost high for exactly 1 cycle after the second HDR1 accept. A following seq 4 gives no pulse, since the tracker resynced to 3.
- MAX_WORDS=9, 11 payload beats -> o_word_count=9; beats 10-11 absent from o_data; o_len_err=1.
- streamId 0 and streamId 33 packets of 4 beats -> each is fully consumed, o_drop pulses once per packet, o_valid never rises.
- Hold i_ready=0 for 5 cycles in OUT while i_valid=1 -> o_ready=0 and o_data stable throughout; the first beat after i_ready is accepted the cycle after the handshake.
- Set SEQ_W=8, tracker at 255, next seq 0 -> no o_packetLost. Assert i_rst_n low mid-PAYLOAD -> o_valid=0 and o_ready=1 immediately; the next seq 1 on that stream gives no pulse.

Source files
------------

// File: rtl/packet_pkg.sv
// Shared FSM encoding and header decode helpers for the packet assembler.
package packet_pkg;

   typedef enum logic [4:0] {
      ST_IDLE    = 5'b00001,
      ST_HDR1    = 5'b00010,
      ST_PAYLOAD = 5'b00100,
      ST_OUT     = 5'b01000,
      ST_DISCARD = 5'b10000
   } state_t;

   // Bit position of each byte lane within a 32-bit header beat
   localparam int unsigned LANE0_LSB = 0;
   localparam int unsigned LANE1_LSB = 8;
   localparam int unsigned LANE2_LSB = 16;
   localparam int unsigned LANE3_LSB = 24;

   // Header fields are little endian per field. A full byte reversal gives:
   //   word 0 -> [31:16] streamId, [15:0] msgLength
   //   word 1 -> [31:0]  seqNumber
   function automatic logic [31:0] hdr_swap(input logic [31:0] w);
      return {w[LANE0_LSB +: 8], w[LANE1_LSB +: 8], w[LANE2_LSB +: 8], w[LANE3_LSB +: 8]};
   endfunction

endpackage

// File: rtl/packet_assembler_seq_tracker.sv
// Per-stream last-seen sequence numbers with a registered gap pulse.
module seq_tracker #(
   parameter int unsigned NUM_STREAMS = 32,
   parameter int unsigned SEQ_W       = 32,
   parameter int unsigned IDX_W       = 5
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [IDX_W-1:0] index,
   input  logic [SEQ_W-1:0] seq,
   input  logic             check,
   output logic             mismatch
);

   logic [SEQ_W-1:0] tbl [NUM_STREAMS];
   logic [SEQ_W-1:0] expected;

   // Next sequence number for the addressed stream, wrapping modulo 2^SEQ_W
   always_comb begin
      expected = tbl[index] + SEQ_W'(1);
   end

   // Flag a gap and always resync the entry to the received number
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
            tbl[i] <= '0;
         end
         mismatch <= 1'b0;
      end else begin
         mismatch <= check && (seq != expected);
         if (check) begin
            tbl[index] <= seq;
         end
      end
   end

endmodule

// File: rtl/packet_assembler.sv
// Header parse, payload packing and length check for a 32-bit beat stream.
module packet_assembler
   import packet_pkg::*;
#(
   parameter int unsigned MAX_WORDS   = 9,
   parameter int unsigned NUM_STREAMS = 32,
   parameter int unsigned SEQ_W       = 32,
   parameter int unsigned CNT_W       = $clog2(MAX_WORDS + 1)
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [31:0]             i_data,
   input  logic                    i_valid,
   input  logic                    i_last,
   output logic                    o_ready,
   output logic [MAX_WORDS*32-1:0] o_data,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic [15:0]             o_stream_id,
   output logic [SEQ_W-1:0]        o_seq,
   output logic [CNT_W-1:0]        o_word_count,
   output logic                    o_len_err,
   output logic                    o_packetLost,
   output logic                    o_drop
);

   localparam int unsigned IDX_W   = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
   localparam logic [15:0] MAX_W16 = 16'(MAX_WORDS);
   localparam logic [15:0] NUM_S16 = 16'(NUM_STREAMS);

   state_t           state;
   logic             accept;
   logic [31:0]      hdr;
   logic             sid_ok;
   logic [15:0]      msg_len;
   logic [15:0]      rcv;
   logic [16:0]      rcv_inc;
   logic [16:0]      exp_beats;
   logic             ovf;
   logic             len_bad;
   logic             trk_check;
   logic [IDX_W-1:0] trk_idx;

   // Handshake, header decode and length comparison for the current beat
   always_comb begin
      accept    = i_valid && o_ready;
      hdr       = hdr_swap(i_data);
      sid_ok    = (hdr[31:16] != 16'd0) && (hdr[31:16] <= NUM_S16);
      rcv_inc   = {1'b0, rcv} + 17'd1;
      exp_beats = ({1'b0, msg_len} + 17'd3) >> 2;
      // Includes the beat being accepted now, so the last beat can overflow too
      len_bad   = (exp_beats != rcv_inc) || ovf || (rcv >= MAX_W16);
      trk_check = accept && (state == ST_HDR1);
      trk_idx   = IDX_W'(o_stream_id - 16'd1);
   end

   // Packet FSM with registered handshake, payload buffer and status outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= ST_IDLE;
         o_ready      <= 1'b1;
         o_valid      <= 1'b0;
         o_data       <= '0;
         o_stream_id  <= '0;
         o_seq        <= '0;
         o_word_count <= '0;
         o_len_err    <= 1'b0;
         o_drop       <= 1'b0;
         msg_len      <= '0;
         rcv          <= '0;
         ovf          <= 1'b0;
      end else begin
         o_drop <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  msg_len     <= hdr[15:0];
                  o_stream_id <= hdr[31:16];
                  if (i_last) begin
                     o_drop <= 1'b1;
                  end else if (!sid_ok) begin
                     state <= ST_DISCARD;
                  end else begin
                     state        <= ST_HDR1;
                     o_data       <= '0;
                     o_word_count <= '0;
                     o_len_err    <= 1'b0;
                     rcv          <= '0;
                     ovf          <= 1'b0;
                  end
               end
            end
            ST_HDR1: begin
               if (accept) begin
                  o_seq <= hdr[SEQ_W-1:0];
                  if (i_last) begin
                     state     <= ST_OUT;
                     o_ready   <= 1'b0;
                     o_valid   <= 1'b1;
                     o_len_err <= (exp_beats != 17'd0);
                  end else begin
                     state <= ST_PAYLOAD;
                  end
               end
            end
            ST_PAYLOAD: begin
               if (accept) begin
                  if (rcv < MAX_W16) begin
                     for (int unsigned w = 0; w < MAX_WORDS; w++) begin
                        if (rcv == 16'(w)) begin
                           o_data[w*32 +: 32] <= i_data;
                        end
                     end
                     o_word_count <= CNT_W'(rcv_inc);
                  end else begin
                     ovf <= 1'b1;
                  end
                  if (rcv != 16'hFFFF) begin
                     rcv <= rcv_inc[15:0];
                  end
                  if (i_last) begin
                     state     <= ST_OUT;
                     o_ready   <= 1'b0;
                     o_valid   <= 1'b1;
                     o_len_err <= len_bad;
                  end
               end
            end
            ST_OUT: begin
               if (i_ready) begin
                  state   <= ST_IDLE;
                  o_valid <= 1'b0;
                  o_ready <= 1'b1;
               end
            end
            ST_DISCARD: begin
               if (accept && i_last) begin
                  state  <= ST_IDLE;
                  o_drop <= 1'b1;
               end
            end
            default: begin
               state   <= ST_IDLE;
               o_ready <= 1'b1;
               o_valid <= 1'b0;
            end
         endcase
      end
   end

   seq_tracker #(
      .NUM_STREAMS(NUM_STREAMS),
      .SEQ_W      (SEQ_W),
      .IDX_W      (IDX_W)
   ) u_seq_tracker (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .index   (trk_idx),
      .seq     (hdr[SEQ_W-1:0]),
      .check   (trk_check),
      .mismatch(o_packetLost)
   );

endmodule

// File: tb/tb_packet_assembler.sv
// Randomised scoreboard bench for packet_assembler (MAX_WORDS=9, NUM_STREAMS=32, SEQ_W=8).
module tb_packet_assembler;

   localparam int MW = 9;
   localparam int NS = 32;

   logic          clk;
   logic          rst_n;
   logic [31:0]   i_data;
   logic          i_valid;
   logic          i_last;
   logic          o_ready;
   logic [MW*32-1:0] o_data;
   logic          o_valid;
   logic          i_ready;
   logic [15:0]   o_stream_id;
   logic [7:0]    o_seq;
   logic [3:0]    o_word_count;
   logic          o_len_err;
   logic          o_packetLost;
   logic          o_drop;

   packet_assembler #(
      .MAX_WORDS  (MW),
      .NUM_STREAMS(NS),
      .SEQ_W      (8)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_data      (i_data),
      .i_valid     (i_valid),
      .i_last      (i_last),
      .o_ready     (o_ready),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_stream_id (o_stream_id),
      .o_seq       (o_seq),
      .o_word_count(o_word_count),
      .o_len_err   (o_len_err),
      .o_packetLost(o_packetLost),
      .o_drop      (o_drop)
   );

   typedef struct {
      logic [15:0]      sid;
      logic [7:0]       seq;
      logic [MW*32-1:0] data;
      logic [3:0]       wc;
      logic             lerr;
   } exp_t;

   exp_t        q[$];
   bit          exp_lost[int];
   bit          exp_drop[int];
   bit          exp_rise[int];
   logic [7:0]  track[NS];
   logic [31:0] pay[16];
   int          nvec = 0;
   int          nfail = 0;
   int          cyc = 0;
   int          rdy_mode = 2;
   bit          gaps_en = 0;
   int          first_acc;
   logic        prev_v = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Downstream ready: 0 random, 1 stall, 2 always ready
   initial begin
      i_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0:       i_ready = ($urandom_range(0, 3) != 0);
            1:       i_ready = 1'b0;
            default: i_ready = 1'b1;
         endcase
      end
   end

   task automatic chk(input string nm, input logic [MW*32-1:0] act, input logic [MW*32-1:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: pulse timing, output latency, stall stability and packet contents
   always @(negedge clk) begin
      chk("packetLost", o_packetLost, exp_lost.exists(cyc) ? 1'b1 : 1'b0);
      chk("drop", o_drop, exp_drop.exists(cyc) ? 1'b1 : 1'b0);
      chk("valid_rise", o_valid && !prev_v, exp_rise.exists(cyc) ? 1'b1 : 1'b0);
      if (o_valid) begin
         chk("ready_in_out", o_ready, 1'b0);
         if (q.size() == 0) begin
            chk("unexpected_output", o_valid, 1'b0);
         end else begin
            chk("out_sid", o_stream_id, q[0].sid);
            chk("out_seq", o_seq, q[0].seq);
            chk("out_data", o_data, q[0].data);
            chk("out_wc", o_word_count, q[0].wc);
            chk("out_len_err", o_len_err, q[0].lerr);
            if (i_ready) void'(q.pop_front());
         end
      end
      prev_v = o_valid;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      nfail++;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] enc_w0(input int sid, input int len);
      logic [15:0] s, l;
      s = 16'(sid);
      l = 16'(len);
      return {l[7:0], l[15:8], s[7:0], s[15:8]};
   endfunction

   function automatic logic [31:0] enc_w1(input logic [31:0] sq);
      return {sq[7:0], sq[15:8], sq[23:16], sq[31:24]};
   endfunction

   // Drive one beat and return the cycle number at which it was accepted
   task automatic send_beat(input logic [31:0] d, input bit last, output int acc);
      bit rdy;
      int waited;
      bit done;
      if (gaps_en && $urandom_range(0, 3) == 0) begin
         i_valid = 1'b0;
         @(posedge clk);
         #1;
      end
      i_data  = d;
      i_last  = last;
      i_valid = 1'b1;
      waited  = 0;
      done    = 0;
      while (!done) begin
         rdy = o_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            done = 1;
         end else begin
            waited++;
            if (waited > 200) begin
               nvec++;
               nfail++;
               $display("FAIL beat_accept_timeout: got no accept, want accept within 200 cycles");
               done = 1;
            end
         end
      end
      acc     = cyc;
      i_valid = 1'b0;
      i_last  = 1'b0;
   endtask

   // Send a whole packet (payload taken from pay[0..n-1]) and record expectations
   task automatic send_packet(input int sid, input logic [31:0] sq, input int len, input int n, input bit runt);
      int   acc;
      exp_t e;
      logic [7:0] nxt;
      if (runt) begin
         send_beat(enc_w0(sid, len), 1'b1, acc);
         first_acc = acc;
         exp_drop[acc] = 1'b1;
         return;
      end
      send_beat(enc_w0(sid, len), 1'b0, acc);
      first_acc = acc;
      if (sid < 1 || sid > NS) begin
         send_beat(enc_w1(sq), n == 0, acc);
         for (int i = 0; i < n; i++) send_beat(pay[i], i == n - 1, acc);
         exp_drop[acc] = 1'b1;
         return;
      end
      e.sid  = 16'(sid);
      e.seq  = sq[7:0];
      e.data = '0;
      for (int i = 0; i < n && i < MW; i++) e.data[i*32 +: 32] = pay[i];
      e.wc   = 4'((n > MW) ? MW : n);
      e.lerr = (((len + 3) / 4) != n) || (n > MW);
      q.push_back(e);
      send_beat(enc_w1(sq), n == 0, acc);
      nxt = track[sid-1] + 8'd1;
      if (sq[7:0] != nxt) exp_lost[acc] = 1'b1;
      track[sid-1] = sq[7:0];
      for (int i = 0; i < n; i++) send_beat(pay[i], i == n - 1, acc);
      exp_rise[acc] = 1'b1;
   endtask

   task automatic wait_drain();
      int t = 0;
      while ((q.size() != 0 || o_valid) && t < 1000) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t >= 1000) begin
         nvec++;
         nfail++;
         $display("FAIL drain_timeout: got %0d pending, want 0", q.size());
      end
   endtask

   initial begin
      int tc;
      int acc;
      int sid, n, len, r;
      logic [31:0] sq;

      rst_n   = 1'b0;
      i_valid = 1'b0;
      i_data  = '0;
      i_last  = 1'b0;
      for (int i = 0; i < NS; i++) track[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", o_ready, 1'b1);
      chk("rst_valid", o_valid, 1'b0);
      chk("rst_data", o_data, '0);
      chk("rst_wc", o_word_count, '0);
      chk("rst_sid", o_stream_id, '0);
      chk("rst_seq", o_seq, '0);
      chk("rst_len_err", o_len_err, 1'b0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic packet: stream 3, seq 1, three payload words
      pay[0] = 32'hAAAA_0001; pay[1] = 32'hBBBB_0002; pay[2] = 32'hCCCC_0003;
      send_packet(3, 32'd1, 12, 3, 0);
      wait_drain();

      // Sequence gap then resync
      pay[0] = 32'h1234_5678;
      send_packet(3, 32'd3, 4, 1, 0);
      send_packet(3, 32'd4, 4, 1, 0);
      wait_drain();

      // Overflow: 11 payload beats
      for (int i = 0; i < 11; i++) pay[i] = 32'hD000_0000 + 32'(i);
      send_packet(4, 32'd1, 44, 11, 0);
      wait_drain();

      // Out-of-range streams are consumed and dropped
      send_packet(0, 32'd9, 8, 2, 0);
      send_packet(33, 32'd9, 8, 2, 0);
      send_packet(6, 32'd0, 0, 0, 1);
      wait_drain();

      // Output held while downstream stalls with input pending
      rdy_mode = 1;
      pay[0] = 32'hCAFE_F00D; pay[1] = 32'hBEEF_0001;
      send_packet(8, 32'd1, 8, 2, 0);
      i_data  = enc_w0(9, 4);
      i_last  = 1'b0;
      i_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         chk("hold_ready", o_ready, 1'b0);
         chk("hold_valid", o_valid, 1'b1);
         if (q.size() > 0) chk("hold_data", o_data, q[0].data);
      end
      rdy_mode = 2;
      tc = cyc;
      pay[0] = 32'h0BAD_F00D;
      send_packet(9, 32'd1, 4, 1, 0);
      chk("hold_accept_cycle", 32'(first_acc), 32'(tc + 2));
      wait_drain();

      // Sequence wrap at SEQ_W=8
      send_packet(5, 32'd255, 0, 0, 0);
      send_packet(5, 32'h0000_0100, 0, 0, 0);
      wait_drain();

      // Asynchronous reset mid-payload
      send_beat(enc_w0(7, 16), 1'b0, acc);
      send_beat(enc_w1(32'd1), 1'b0, acc);
      send_beat(32'h7777_0000, 1'b0, acc);
      send_beat(32'h7777_0001, 1'b0, acc);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", o_valid, 1'b0);
      chk("midrst_ready", o_ready, 1'b1);
      chk("midrst_wc", o_word_count, '0);
      for (int i = 0; i < NS; i++) track[i] = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      pay[0] = 32'h5555_AAAA;
      send_packet(7, 32'd1, 4, 1, 0);
      wait_drain();

      // Randomised traffic with random downstream back-pressure
      rdy_mode = 0;
      gaps_en  = 1;
      for (int p = 0; p < 80; p++) begin
         r = $urandom_range(0, 19);
         if (r == 1) sid = 0;
         else if (r == 2) sid = $urandom_range(33, 40);
         else if (r == 3) sid = $urandom_range(1, NS);
         else sid = $urandom_range(1, 4);
         n = $urandom_range(0, 11);
         for (int i = 0; i < n; i++) pay[i] = $urandom;
         if ($urandom_range(0, 1) == 0 && sid >= 1 && sid <= NS) sq = 32'(track[sid-1]) + 32'd1 + ($urandom & 32'hFFFF_FF00);
         else sq = $urandom;
         if ($urandom_range(0, 2) != 0) len = n * 4 - ((n > 0) ? $urandom_range(0, 3) : 0);
         else len = $urandom_range(0, 60);
         send_packet(sid, sq, len, n, r == 0);
      end
      wait_drain();
      rdy_mode = 2;
      repeat (3) @(posedge clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
